// File: rtl/crtc_pkg.sv
// Shared register indices, cursor blink codes and register width masks for the CRTC.
package crtc_pkg;

   localparam int unsigned NumRegs = 16;

   localparam logic [3:0] R_HTOTAL = 4'd0;
   localparam logic [3:0] R_HDISP  = 4'd1;
   localparam logic [3:0] R_HSYNC  = 4'd2;
   localparam logic [3:0] R_SYNCW  = 4'd3;
   localparam logic [3:0] R_VTOTAL = 4'd4;
   localparam logic [3:0] R_VADJ   = 4'd5;
   localparam logic [3:0] R_VDISP  = 4'd6;
   localparam logic [3:0] R_VSYNC  = 4'd7;
   localparam logic [3:0] R_MODE   = 4'd8;
   localparam logic [3:0] R_MAXRA  = 4'd9;
   localparam logic [3:0] R_CURS   = 4'd10;
   localparam logic [3:0] R_CURE   = 4'd11;
   localparam logic [3:0] R_STARTH = 4'd12;
   localparam logic [3:0] R_STARTL = 4'd13;
   localparam logic [3:0] R_CURH   = 4'd14;
   localparam logic [3:0] R_CURL   = 4'd15;

   // Cursor display mode held in R10[6:5]
   typedef enum logic [1:0] {
      BlinkSteady = 2'b00,
      BlinkOff    = 2'b01,
      Blink16     = 2'b10,
      Blink32     = 2'b11
   } blink_e;

   // Bits actually implemented in each register; unimplemented bits store as 0
   function automatic logic [7:0] reg_mask(input logic [3:0] idx);
      logic [7:0] m;
      case (idx)
         R_VTOTAL, R_VDISP, R_VSYNC, R_CURS: m = 8'h7F;
         R_VADJ, R_MAXRA, R_CURE:           m = 8'h1F;
         R_STARTH, R_CURH:                  m = 8'h3F;
         default:                           m = 8'hFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/crtc_regs.sv
// CPU-facing register file: address register, edge-detected writes, masking and read mux.
module crtc_regs
   import crtc_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             cs_i,
   input  logic             rs_i,
   input  logic             wr_i,
   input  logic [7:0]       d_i,
   output logic [7:0]       q_o,
   output logic [15:0][7:0] regs_o
);

   logic             wr_act;
   logic             wr_act_q;
   logic             wr_stb;
   logic [4:0]       ar_q;
   logic [15:0][7:0] regs_q;

   assign wr_act = !cs_i && !wr_i;
   // A held strobe only writes on its first clock
   assign wr_stb = wr_act && !wr_act_q;

   // Address register, register array and strobe history
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_act_q <= 1'b0;
         ar_q     <= '0;
         regs_q   <= '0;
      end else begin
         wr_act_q <= wr_act;
         if (wr_stb) begin
            if (!rs_i) begin
               ar_q <= d_i[4:0];
            end else if (!ar_q[4]) begin
               regs_q[ar_q[3:0]] <= d_i & reg_mask(ar_q[3:0]);
            end
         end
      end
   end

   // Only R12..R15 are readable; everything else reads as zero
   always_comb begin
      q_o = 8'h00;
      if (rs_i && (ar_q[4:2] == 3'b011)) begin
         q_o = regs_q[ar_q[3:0]];
      end
   end

   assign regs_o = regs_q;

endmodule

// File: rtl/crtc6845.sv
// MC6845-compatible CRT controller: timing counters, syncs, refresh address and cursor.
module crtc6845
   import crtc_pkg::*;
#(
   parameter int unsigned MAW = 14,
   parameter int unsigned RAW = 5
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           cep,
   input  logic           cs,
   input  logic           rs,
   input  logic           wr,
   input  logic [7:0]     d,
   output logic [7:0]     q,
   output logic           hsync,
   output logic           vsync,
   output logic           de,
   output logic           cur,
   output logic [MAW-1:0] ma,
   output logic [RAW-1:0] ra
);

   logic [15:0][7:0] r;

   logic [7:0]     hc_q, hc_d;
   logic [4:0]     ra_q, ra_d;
   logic [6:0]     vc_q, vc_d;
   logic           adj_q, adj_d;
   logic           hs_act_q, hs_act_d;
   logic [3:0]     hs_cnt_q, hs_cnt_d;
   logic           vs_act_q, vs_act_d;
   logic [3:0]     vs_cnt_q, vs_cnt_d;
   logic [MAW-1:0] ma_q, ma_d;
   logic [MAW-1:0] row_q, row_d;
   logic [4:0]     fc_q, fc_d;

   logic           hsync_q, vsync_q, de_q, cur_q;
   logic [MAW-1:0] ma_out_q;
   logic [RAW-1:0] ra_out_q;

   logic           eol, row_last, row_end, frame_row, adj_last, sof;
   logic           hs_now, de_now, cur_now, blink_on, vs_start;
   logic [MAW-1:0] start_addr, cur_addr, row_next;

   crtc_regs u_regs (
      .clock  (clock),
      .reset  (reset),
      .cs_i   (cs),
      .rs_i   (rs),
      .wr_i   (wr),
      .d_i    (d),
      .q_o    (q),
      .regs_o (r)
   );

   assign start_addr = MAW'({r[R_STARTH][5:0], r[R_STARTL]});
   assign cur_addr   = MAW'({r[R_CURH][5:0], r[R_CURL]});
   assign row_next   = row_q + MAW'(r[R_HDISP]);

   assign eol       = (hc_q == r[R_HTOTAL]);
   assign row_last  = (ra_q == r[R_MAXRA][4:0]);
   assign row_end   = !adj_q && row_last;
   assign frame_row = (vc_q == r[R_VTOTAL][6:0]);
   assign adj_last  = ((ra_q + 5'd1) == r[R_VADJ][4:0]);
   assign sof       = eol && ((row_end && frame_row && (r[R_VADJ][4:0] == 5'd0)) ||
                              (adj_q && adj_last));

   assign de_now = (hc_q < r[R_HDISP]) && (vc_q < r[R_VDISP][6:0]) && !adj_q;
   assign hs_now = hs_act_q || (hc_q == r[R_HSYNC]);

   // Cursor blink gate from R10[6:5] and the frame counter phase
   always_comb begin
      blink_on = 1'b1;
      unique case (blink_e'(r[R_CURS][6:5]))
         BlinkSteady: blink_on = 1'b1;
         BlinkOff:    blink_on = 1'b0;
         Blink16:     blink_on = !fc_q[3];
         Blink32:     blink_on = !fc_q[4];
      endcase
   end

   assign cur_now = de_now && blink_on && (ma_q == cur_addr) &&
                    (ra_q >= r[R_CURS][4:0]) && (ra_q <= r[R_CURE][4:0]);

   // Horizontal counter and hsync width counter
   always_comb begin
      hc_d     = hc_q;
      hs_act_d = hs_act_q;
      hs_cnt_d = hs_cnt_q;
      if (cep) begin
         hc_d = eol ? 8'd0 : hc_q + 8'd1;
         if (hs_act_q) begin
            hs_cnt_d = hs_cnt_q + 4'd1;
            hs_act_d = ((hs_cnt_q + 4'd1) != r[R_SYNCW][3:0]);
         end else if (hc_q == r[R_HSYNC]) begin
            hs_cnt_d = 4'd1;
            hs_act_d = (4'd1 != r[R_SYNCW][3:0]);
         end
      end
   end

   // Raster, row and adjust-phase counters; they move only at end of line
   always_comb begin
      ra_d  = ra_q;
      vc_d  = vc_q;
      adj_d = adj_q;
      fc_d  = fc_q;
      if (cep && eol) begin
         if (sof) begin
            ra_d  = '0;
            vc_d  = '0;
            adj_d = 1'b0;
            fc_d  = fc_q + 5'd1;
         end else if (adj_q) begin
            ra_d = ra_q + 5'd1;
         end else if (row_last) begin
            ra_d = '0;
            if (frame_row) begin
               adj_d = 1'b1;
            end else begin
               vc_d = vc_q + 7'd1;
            end
         end else begin
            ra_d = ra_q + 5'd1;
         end
      end
   end

   // A new pulse starts only on the first line of row R7, never mid-pulse
   assign vs_start = !adj_d && (ra_d == 5'd0) && (vc_d == r[R_VSYNC][6:0]);

   // Vsync line counter, updated at line boundaries
   always_comb begin
      vs_act_d = vs_act_q;
      vs_cnt_d = vs_cnt_q;
      if (cep && eol) begin
         if (vs_act_q) begin
            if (vs_cnt_q == r[R_SYNCW][7:4]) begin
               vs_act_d = 1'b0;
            end else begin
               vs_cnt_d = vs_cnt_q + 4'd1;
            end
         end else if (vs_start) begin
            vs_act_d = 1'b1;
            vs_cnt_d = 4'd1;
         end
      end
   end

   // Refresh address; start-of-frame addressing overrides end-of-line addressing
   always_comb begin
      ma_d  = ma_q;
      row_d = row_q;
      if (cep) begin
         if (sof) begin
            row_d = start_addr;
            ma_d  = start_addr;
         end else if (eol) begin
            if (row_end) begin
               row_d = row_next;
               ma_d  = row_next;
            end else begin
               ma_d = row_q;
            end
         end else begin
            ma_d = ma_q + MAW'(1);
         end
      end
   end

   // Counter state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hc_q     <= '0;
         ra_q     <= '0;
         vc_q     <= '0;
         adj_q    <= 1'b0;
         hs_act_q <= 1'b0;
         hs_cnt_q <= '0;
         vs_act_q <= 1'b0;
         vs_cnt_q <= '0;
         ma_q     <= '0;
         row_q    <= '0;
         fc_q     <= '0;
      end else begin
         hc_q     <= hc_d;
         ra_q     <= ra_d;
         vc_q     <= vc_d;
         adj_q    <= adj_d;
         hs_act_q <= hs_act_d;
         hs_cnt_q <= hs_cnt_d;
         vs_act_q <= vs_act_d;
         vs_cnt_q <= vs_cnt_d;
         ma_q     <= ma_d;
         row_q    <= row_d;
         fc_q     <= fc_d;
      end
   end

   // Registered outputs describe the character the cep just consumed
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hsync_q  <= 1'b0;
         vsync_q  <= 1'b0;
         de_q     <= 1'b0;
         cur_q    <= 1'b0;
         ma_out_q <= '0;
         ra_out_q <= '0;
      end else if (cep) begin
         hsync_q  <= hs_now;
         vsync_q  <= vs_act_q;
         de_q     <= de_now;
         cur_q    <= cur_now;
         ma_out_q <= ma_q;
         ra_out_q <= RAW'(ra_q);
      end
   end

   assign hsync = hsync_q;
   assign vsync = vsync_q;
   assign de    = de_q;
   assign cur   = cur_q;
   assign ma    = ma_out_q;
   assign ra    = ra_out_q;

   logic unused_bits;
   assign unused_bits = ^{r[R_VTOTAL][7], r[R_VADJ][7:5], r[R_VDISP][7], r[R_VSYNC][7],
                          r[R_MODE], r[R_MAXRA][7:5], r[R_CURS][7], r[R_CURE][7:5],
                          r[R_STARTH][7:6], r[R_CURH][7:6]};

endmodule

// File: tb/tb_crtc6845.sv
// Self-checking bench for crtc6845: reference model scoreboard plus hand-derived patterns.
module tb_crtc6845;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cep   = 1'b0;
   logic        cs    = 1'b1;
   logic        rs    = 1'b0;
   logic        wr    = 1'b1;
   logic [7:0]  d     = 8'h00;
   logic [7:0]  q;
   logic        hsync, vsync, de, cur;
   logic [13:0] ma;
   logic [4:0]  ra;

   crtc6845 #(.MAW(14), .RAW(5)) dut (
      .clock (clock),
      .reset (reset),
      .cep   (cep),
      .cs    (cs),
      .rs    (rs),
      .wr    (wr),
      .d     (d),
      .q     (q),
      .hsync (hsync),
      .vsync (vsync),
      .de    (de),
      .cur   (cur),
      .ma    (ma),
      .ra    (ra)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic        cur;
      logic [13:0] ma;
      logic [4:0]  ra;
   } out_t;

   out_t       exp_q[$];
   logic [7:0] rd_q[$];
   int vectors = 0;
   int errors  = 0;

   // Reference model state
   logic [7:0] m_r [16];
   int m_ar, m_hc, m_ra, m_vc, m_adj, m_ma, m_row, m_hs_left, m_vs_left, m_fc;

   function automatic logic [7:0] mask_of(input int i);
      if (i == 4 || i == 6 || i == 7 || i == 10) return 8'h7F;
      if (i == 5 || i == 9 || i == 11) return 8'h1F;
      if (i == 12 || i == 14) return 8'h3F;
      return 8'hFF;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_r[i] = 8'h00;
      m_ar = 0; m_hc = 0; m_ra = 0; m_vc = 0; m_adj = 0; m_ma = 0; m_row = 0;
      m_hs_left = 0; m_vs_left = 0; m_fc = 0;
   endtask

   // Output for the current character, then advance one character
   function automatic out_t model_step();
      out_t o;
      int   w, vw, mode;
      bit   eol, sof, rowend, blink;
      w  = (m_r[3][3:0] == 0) ? 16 : int'(m_r[3][3:0]);
      vw = (m_r[3][7:4] == 0) ? 16 : int'(m_r[3][7:4]);
      o.de = (m_hc < m_r[1]) && (m_vc < m_r[6]) && (m_adj == 0);
      if (m_hs_left == 0 && m_hc == m_r[2]) m_hs_left = w;
      o.hs = (m_hs_left > 0);
      if (m_hs_left > 0) m_hs_left--;
      o.vs = (m_vs_left > 0);
      o.ma = m_ma[13:0];
      o.ra = m_ra[4:0];
      mode = int'(m_r[10][6:5]);
      blink = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : (mode == 2) ? ((m_fc % 16) < 8)
                                                                    : (m_fc < 16);
      o.cur = o.de && blink && (m_ma == int'({m_r[14][5:0], m_r[15]})) &&
              (m_ra >= int'(m_r[10][4:0])) && (m_ra <= int'(m_r[11]));
      eol = (m_hc == m_r[0]);
      m_hc = eol ? 0 : (m_hc + 1) % 256;
      if (eol) begin
         rowend = (m_adj == 0) && (m_ra == m_r[9]);
         sof = 1'b0;
         if (m_adj != 0) begin
            if ((m_ra + 1) % 32 == m_r[5]) sof = 1'b1;
            else m_ra++;
         end else if (rowend) begin
            if (m_vc == m_r[4]) begin
               if (m_r[5] == 0) sof = 1'b1;
               else begin m_adj = 1; m_ra = 0; end
            end else begin
               m_vc = (m_vc + 1) % 128; m_ra = 0;
            end
         end else m_ra = (m_ra + 1) % 32;
         if (sof) begin m_adj = 0; m_vc = 0; m_ra = 0; m_fc = (m_fc + 1) % 32; end
         if (m_vs_left > 0) m_vs_left--;
         else if (m_adj == 0 && m_ra == 0 && m_vc == m_r[7]) m_vs_left = vw;
         if (sof) begin m_row = int'({m_r[12][5:0], m_r[13]}); m_ma = m_row; end
         else if (rowend) begin m_row = (m_row + m_r[1]) % 16384; m_ma = m_row; end
         else m_ma = m_row;
      end else m_ma = (m_ma + 1) % 16384;
      return o;
   endfunction

   // Hand-derived outputs for register set A, cep index k counted from reset
   function automatic out_t lit_a(input int k);
      out_t o;
      int f, l, c;
      f = k / 70; l = (k % 70) / 10; c = k % 10;
      o.de  = (c < 6) && (l < 4);
      o.hs  = (c == 7) || (c == 8);
      o.vs  = (l == 4) || (l == 5);
      o.ra  = 5'((l < 6) ? l % 2 : 0);
      o.ma  = 14'(((f == 0) ? 0 : 'h110) + (l / 2) * 6 + c);
      o.cur = (f == 0) && (l == 0) && (c == 0);
      return o;
   endfunction

   function automatic out_t dut_out();
      return {de, hsync, vsync, cur, ma, ra};
   endfunction

   task automatic bus_write(input logic rsv, input logic [7:0] val);
      @(negedge clock);
      cs = 1'b0; rs = rsv; d = val; wr = 1'b0;
      @(negedge clock);
      cs = 1'b1; wr = 1'b1;
      if (!rsv) m_ar = int'(val[4:0]);
      else if (m_ar < 16) m_r[m_ar] = val & mask_of(m_ar);
   endtask

   task automatic set_reg(input int idx, input logic [7:0] val);
      bus_write(1'b0, 8'(idx));
      bus_write(1'b1, val);
   endtask

   task automatic program_a();
      set_reg(0, 8'd9);  set_reg(1, 8'd6);  set_reg(2, 8'd7);  set_reg(3, 8'h22);
      set_reg(4, 8'd2);  set_reg(5, 8'd1);  set_reg(6, 8'd2);  set_reg(7, 8'd2);
      set_reg(9, 8'd1);  set_reg(12, 8'h01); set_reg(13, 8'h10);
   endtask

   task automatic do_reset();
      @(negedge clock);
      cs = 1'b1; wr = 1'b1; rs = 1'b0; cep = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      exp_q.delete();
   endtask

   // Push the model's expectation, pulse cep once, leave one idle clock
   task automatic cep_step();
      exp_q.push_back(model_step());
      cep = 1'b1;
      @(negedge clock);
      cep = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset();
      out_t g, e;
      do_reset();
      program_a();
      for (int k = 0; k < 13; k++) begin
         cep_step();
         e = exp_q.pop_front(); g = dut_out(); vectors++;
         if (g !== e) begin
            errors++; $display("FAIL reset_pre k=%0d got %h want %h", k, g, e);
         end
      end
      bus_write(1'b0, 8'd12);
      rs = 1'b1;
      rd_q.push_back(8'h01);
      #1;
      vectors++;
      if (q !== rd_q[0]) begin errors++; $display("FAIL reset_pre_q got %h want %h", q, rd_q[0]); end
      void'(rd_q.pop_front());
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      vectors++;
      if ({dut_out(), q} !== 31'h0) begin
         errors++; $display("FAIL reset_async got %h q=%h want 0", dut_out(), q);
      end
      @(negedge clock);
      reset = 1'b0; rs = 1'b0;
      model_reset(); exp_q.delete();
      cep_step();
      e = exp_q.pop_front(); g = dut_out(); vectors++;
      if (g !== e || g.ma !== 14'd0 || g.ra !== 5'd0 || g.de !== 1'b0 || g.hs !== 1'b1) begin
         errors++; $display("FAIL reset_first_cep got %h want %h", g, e);
      end
   endtask

   task automatic test_htiming();
      out_t g, e, l;
      int   de_cnt;
      do_reset();
      program_a();
      de_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         cep_step();
         e = exp_q.pop_front(); g = dut_out(); l = lit_a(k); vectors++;
         if (g !== e || g.de !== l.de || g.hs !== l.hs) begin
            errors++; $display("FAIL htiming k=%0d got %h model %h fixed %h", k, g, e, l);
         end
         if (k < 10 && g.de) de_cnt++;
      end
      vectors++;
      if (de_cnt !== 6) begin errors++; $display("FAIL hde_count got %0d want 6", de_cnt); end
   endtask

   // Continues from test_htiming: rest of frame 0 and all of frame 1
   task automatic test_vtiming_address();
      out_t g, e, l;
      for (int k = 20; k < 140; k++) begin
         cep_step();
         e = exp_q.pop_front(); g = dut_out(); l = lit_a(k); vectors++;
         if (g !== e || g !== l) begin
            errors++; $display("FAIL vtim_addr k=%0d got %h model %h fixed %h", k, g, e, l);
         end
      end
   endtask

   task automatic test_cursor();
      out_t g, e;
      int   f, ln, c;
      logic want;
      do_reset();
      program_a();
      set_reg(9, 8'd4); set_reg(14, 8'h01); set_reg(15, 8'h12);
      set_reg(10, 8'h43); set_reg(11, 8'd4);
      for (int k = 0; k < 24 * 160; k++) begin
         cep_step();
         f = k / 160; ln = (k % 160) / 10; c = k % 10;
         want = (f >= 1) && ((f % 16) < 8) && (ln == 3 || ln == 4) && (c == 2);
         e = exp_q.pop_front(); g = dut_out(); vectors++;
         if (g !== e || g.cur !== want) begin
            errors++; $display("FAIL cursor_blink k=%0d got %h model %h cur_want %b", k, g, e, want);
         end
      end
      set_reg(10, 8'h23);
      for (int k = 0; k < 160; k++) begin
         cep_step();
         e = exp_q.pop_front(); g = dut_out(); vectors++;
         if (g !== e || g.cur !== 1'b0) begin
            errors++; $display("FAIL cursor_off k=%0d got %h model %h", k, g, e);
         end
      end
   endtask

   task automatic test_r0_lower();
      out_t g, e;
      do_reset();
      program_a();
      for (int k = 0; k < 8; k++) begin
         cep_step();
         void'(exp_q.pop_front());
      end
      set_reg(0, 8'd3);
      for (int k = 0; k < 270; k++) begin
         cep_step();
         e = exp_q.pop_front(); g = dut_out(); vectors++;
         if (g !== e || (k < 248 && (g.ma !== 14'(8 + k) || g.de !== 1'b0))) begin
            errors++; $display("FAIL r0_lower k=%0d got %h model %h", k, g, e);
         end
      end
   endtask

   task automatic test_bus();
      logic [7:0] got;
      do_reset();
      set_reg(5, 8'h1F);
      rs = 1'b1; rd_q.push_back(8'h00); #1 got = q; vectors++;
      if (got !== rd_q.pop_front()) begin errors++; $display("FAIL rd_r5 got %h want 00", got); end
      bus_write(1'b0, 8'hEE);
      bus_write(1'b1, 8'hFF);
      rs = 1'b1; rd_q.push_back(8'h3F); #1 got = q; vectors++;
      if (got !== rd_q.pop_front()) begin errors++; $display("FAIL rd_r14 got %h want 3F", got); end
      rs = 1'b0; rd_q.push_back(8'h00); #1 got = q; vectors++;
      if (got !== rd_q.pop_front()) begin errors++; $display("FAIL rd_rs0 got %h want 00", got); end
      bus_write(1'b0, 8'd15);
      @(negedge clock);
      cs = 1'b1; rs = 1'b1; d = 8'h55; wr = 1'b0;
      @(negedge clock);
      wr = 1'b1; rd_q.push_back(8'h00); #1 got = q; vectors++;
      if (got !== rd_q.pop_front()) begin errors++; $display("FAIL cs_high got %h want 00", got); end
      bus_write(1'b0, 8'd12);
      @(negedge clock);
      cs = 1'b0; rs = 1'b1; d = 8'h05; wr = 1'b0;
      @(negedge clock);
      d = 8'h2A;
      repeat (19) @(negedge clock);
      cs = 1'b1; wr = 1'b1;
      rd_q.push_back(8'h05); #1 got = q; vectors++;
      if (got !== rd_q.pop_front()) begin errors++; $display("FAIL long_strobe got %h want 05", got); end
      bus_write(1'b0, 8'h1C);
      bus_write(1'b1, 8'h3C);
      rs = 1'b1; rd_q.push_back(8'h00); #1 got = q; vectors++;
      if (got !== rd_q.pop_front()) begin errors++; $display("FAIL rd_ar28 got %h want 00", got); end
      bus_write(1'b0, 8'd12);
      rs = 1'b1; rd_q.push_back(8'h05); #1 got = q; vectors++;
      if (got !== rd_q.pop_front()) begin errors++; $display("FAIL ar_gt15 got %h want 05", got); end
      rs = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      test_reset();
      test_htiming();
      test_vtiming_address();
      test_cursor();
      test_r0_lower();
      test_bus();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
